// File: rtl/fp_round_pipe_if.sv
// fp_round_pipe_if: valid/ready input stream (unrounded operand) and output stream (rounded result).
interface fp_round_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W+2:0] in_mant;
    logic [1:0]        in_rm;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_inexact;
    logic              out_overflow;
    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow
    );
endinterface

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage FP mantissa rounder; S1 decides the increment, S2 applies it
// and resolves mantissa carry and exponent overflow.
module fp_round_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input logic           clk,
    input logic           rst_n,
    fp_round_pipe_if.slave bus
);
    logic              s1_valid_q, s1_sign_q, s1_inc_q, s1_inexact_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_mant_q;
    logic              s2_valid_q, out_sign_q, out_inexact_q, out_overflow_q;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d, exp_inc;
    logic [MANT_W-1:0] out_mant_q, out_mant_d;
    logic [MANT_W:0]   sum;
    logic              s2_adv, s1_adv, in_rdy, exp_max, inexact_d, inc_d, carry, ovf_d;
    always_comb begin
        s2_adv    = bus.out_ready || !s2_valid_q;
        s1_adv    = s1_valid_q && s2_adv;
        in_rdy    = !s1_valid_q || s1_adv;
        // inf/NaN must pass untouched, so rounding is suppressed entirely
        exp_max   = &bus.in_exp;
        inexact_d = (|bus.in_mant[2:0]) && !exp_max;
        inc_d     = !exp_max && (bus.in_rm == 2'd0 ? bus.in_mant[2] && (bus.in_mant[1] || bus.in_mant[0] || bus.in_mant[3]) :
                                 bus.in_rm == 2'd2 ? !bus.in_sign && inexact_d :
                                 bus.in_rm == 2'd3 ? bus.in_sign && inexact_d : 1'b0);
        sum        = {1'b0, s1_mant_q} + {{MANT_W{1'b0}}, s1_inc_q};
        carry      = sum[MANT_W];
        exp_inc    = s1_exp_q + 1'b1;
        ovf_d      = carry && (&exp_inc);
        out_exp_d  = carry ? exp_inc : s1_exp_q;
        out_mant_d = ovf_d ? '0 : carry ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_inc_q       <= 1'b0;
            s1_inexact_q   <= 1'b0;
            s1_exp_q       <= '0;
            s1_mant_q      <= '0;
            s2_valid_q     <= 1'b0;
            out_sign_q     <= 1'b0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
            out_exp_q      <= '0;
            out_mant_q     <= '0;
        end else begin
            if (in_rdy) s1_valid_q <= bus.in_valid;
            if (in_rdy && bus.in_valid) begin
                s1_sign_q    <= bus.in_sign;
                s1_exp_q     <= bus.in_exp;
                s1_mant_q    <= bus.in_mant[MANT_W+2:3];
                s1_inc_q     <= inc_d;
                s1_inexact_q <= inexact_d;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s1_adv) begin
                out_sign_q     <= s1_sign_q;
                out_exp_q      <= out_exp_d;
                out_mant_q     <= out_mant_d;
                out_inexact_q  <= s1_inexact_q || ovf_d;
                out_overflow_q <= ovf_d;
            end
        end
    end
    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_sign     = out_sign_q;
    assign bus.out_exp      = out_exp_q;
    assign bus.out_mant     = out_mant_q;
    assign bus.out_inexact  = out_inexact_q;
    assign bus.out_overflow = out_overflow_q;
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed and randomized checks of fp_round_pipe against an arithmetic rounding model.
module tb_fp_round_pipe;
    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        inx;
        logic        ovf;
    } res_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic held = 1'b0;
    res_t held_val;
    fp_round_pipe_if #(.MANT_W(24), .EXP_W(8)) bus ();
    fp_round_pipe #(.MANT_W(24), .EXP_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask
    // Round value m/8 to an integer per mode, then renormalise on 2^24.
    function automatic res_t model(input logic s, input logic [7:0] e, input logic [26:0] m, input logic [1:0] rm);
        int unsigned t = m >> 3;
        int unsigned rem = m & 7;
        int ex = e;
        logic up;
        if (e == 8'hFF) return '{s, e, t[23:0], 1'b0, 1'b0};
        up = rm == 0 ? (rem > 4 || (rem == 4 && t % 2 == 1)) :
             rm == 2 ? (!s && rem != 0) :
             rm == 3 ? (s && rem != 0) : 1'b0;
        t = t + up;
        if (t == (1 << 24)) begin
            t = 1 << 23;
            ex = ex + 1;
        end
        if (ex == 255) return '{s, 8'hFF, 24'h0, 1'b1, 1'b1};
        return '{s, 8'(ex), t[23:0], rem != 0, 1'b0};
    endfunction
    task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic [1:0] rm, input logic ordy);
        bus.in_valid  = v;
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mant   = m;
        bus.in_rm     = rm;
        bus.out_ready = ordy;
    endtask
    task automatic tick();
        res_t cur;
        #1;
        cur = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow};
        if (held) chk("hold", cur, held_val);
        held = bus.out_valid && !bus.out_ready;
        held_val = cur;
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_rm));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious", bus.out_valid, 0);
            else chk("result", cur, exp_q.pop_front());
        end
        @(negedge clk);
    endtask
    task automatic dir(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m, input logic [1:0] rm,
                       input logic [23:0] xm, input logic [7:0] xe, input logic xi, input logic xo);
        drive(1, s, e, m, rm, 1);
        #1 chk({tag, "_rdy"}, bus.in_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk({tag, "_lat1"}, bus.out_valid, 0);
        tick();
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_mant"}, bus.out_mant, xm);
        chk({tag, "_exp"}, bus.out_exp, xe);
        chk({tag, "_inx"}, bus.out_inexact, xi);
        chk({tag, "_ovf"}, bus.out_overflow, xo);
        chk({tag, "_sign"}, bus.out_sign, s);
        tick();
    endtask
    initial begin
        int acc, got;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_data", {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rdy", bus.in_ready, 1);
        @(negedge clk);
        dir("tie_even", 0, 8'h10, 27'h4000004, 0, 24'h800000, 8'h10, 1, 0);
        dir("tie_odd",  0, 8'h10, 27'h400000C, 0, 24'h800002, 8'h10, 1, 0);
        dir("rtz",      0, 8'h10, 27'h400000C, 1, 24'h800001, 8'h10, 1, 0);
        dir("carry",    0, 8'h10, 27'h7FFFFFC, 0, 24'h800000, 8'h11, 1, 0);
        dir("ovf",      0, 8'hFE, 27'h7FFFFFC, 0, 24'h000000, 8'hFF, 1, 1);
        dir("rup_pos",  0, 8'h10, 27'h4000001, 2, 24'h800001, 8'h10, 1, 0);
        dir("rup_neg",  1, 8'h10, 27'h4000001, 2, 24'h800000, 8'h10, 1, 0);
        dir("rdn_neg",  1, 8'h10, 27'h4000001, 3, 24'h800001, 8'h10, 1, 0);
        dir("inf_nan",  0, 8'hFF, 27'h4000007, 0, 24'h800000, 8'hFF, 0, 0);
        dir("zero",     1, 8'h20, 27'h0000000, 2, 24'h000000, 8'h20, 0, 0);
        // backpressure: only two beats fit while the output is stalled
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 8'(8'h20 + acc), 27'(8 * (acc + 1)), 1, 0);
            #1 chk("bp_rdy", bus.in_ready, c < 2);
            if (bus.in_ready) acc++;
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            #1 chk("bp_stall_rdy", bus.in_ready, 0);
            chk("bp_stall_vld", bus.out_valid, 1);
            tick();
        end
        got = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            if (acc < 4) drive(1, 0, 8'(8'h20 + acc), 27'(8 * (acc + 1)), 1, 1);
            else drive(0, 0, 0, 0, 0, 1);
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_order", bus.out_exp, 8'h20 + got);
                got++;
            end
            tick();
        end
        chk("bp_count", got, 4);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("bp_extra", bus.out_valid, 0);
        // reset with two beats in flight
        drive(1, 0, 8'h30, 27'h1234567, 0, 1);
        tick();
        drive(1, 1, 8'h31, 27'h2345678, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1 chk("pre_rst_vld", bus.out_valid, 1);
        rst_n = 1'b0;
        #1 chk("mid_rst_vld", bus.out_valid, 0);
        chk("mid_rst_mant", bus.out_mant, 0);
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stale", bus.out_valid, 0);
            tick();
        end
        dir("post_rst", 0, 8'h40, 27'h4000004, 0, 24'h800000, 8'h40, 1, 0);
        // randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            logic [26:0] m;
            logic [7:0] e;
            int cat;
            cat = $urandom_range(0, 7);
            m = 27'($urandom);
            e = 8'($urandom_range(1, 254));
            if (cat == 0) m = '0;
            if (cat == 1) e = 8'hFF;
            if (cat == 2) m = {24'hFFFFFF, 3'($urandom)};
            if (cat == 3) begin
                m = {24'hFFFFFF, 3'($urandom)};
                e = 8'hFE;
            end
            drive($urandom_range(0, 9) < 7, 1'($urandom), e, m, 2'($urandom), $urandom_range(0, 9) < 7);
            tick();
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
        end
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
